// File: rtl/fsm3_rr_scheduler_if.sv
// Bus bundle for fsm3_rr_scheduler: request handshake, per-step results and the counter read port.
// The master side is the set of bit producers / result consumers; the slave side is the scheduler.
interface fsm3_rr_scheduler_if #(
   parameter int NCH   = 4,
   parameter int CH_W  = $clog2(NCH),
   parameter int CNT_W = 8
);
   logic [NCH-1:0]   req_valid;
   logic [NCH-1:0]   req_din;
   logic [NCH-1:0]   req_ready;
   logic [NCH-1:0]   ch_clear;
   logic             out_valid;
   logic [CH_W-1:0]  out_ch;
   logic             out_dout;
   logic [NCH-1:0]   dout_vec;
   logic [CH_W-1:0]  rd_ch;
   logic [CNT_W-1:0] rd_cnt;
   logic [2*NCH-1:0] ctx_dbg;

   modport master (
      output req_valid, req_din, ch_clear, rd_ch,
      input  req_ready, out_valid, out_ch, out_dout, dout_vec, rd_cnt, ctx_dbg
   );

   modport slave (
      input  req_valid, req_din, ch_clear, rd_ch,
      output req_ready, out_valid, out_ch, out_dout, dout_vec, rd_cnt, ctx_dbg
   );
endinterface

// File: rtl/fsm3_rr_scheduler.sv
// Round-robin scheduler sharing one fsm3 next-state evaluator across NCH bit streams,
// with per-channel state contexts and saturating per-channel detection counters.
module fsm3_rr_scheduler #(
   parameter int NCH   = 4,
   parameter int CH_W  = $clog2(NCH),
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               areset_n,
   fsm3_rr_scheduler_if.slave bus
);
   localparam logic [1:0]       ST_A    = 2'd0;
   localparam logic [1:0]       ST_B    = 2'd1;
   localparam logic [1:0]       ST_C    = 2'd2;
   localparam logic [1:0]       ST_D    = 2'd3;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [1:0]       state_q [NCH];
   logic [CNT_W-1:0] cnt_q   [NCH];
   logic [CH_W-1:0]  ptr_q;
   logic             out_valid_q;
   logic [CH_W-1:0]  out_ch_q;
   logic             out_dout_q;

   logic [NCH-1:0]   eligible;
   logic [NCH-1:0]   grant;
   logic             xfer;
   logic [CH_W-1:0]  gnt_ch;
   logic [CH_W-1:0]  cand;
   logic [1:0]       gnt_next;

   function automatic logic [1:0] fsm3_next(input logic [1:0] s, input logic din);
      logic [1:0] n;
      case (s)
         ST_A:    n = din ? ST_B : ST_A;
         ST_B:    n = din ? ST_B : ST_C;
         ST_C:    n = din ? ST_D : ST_A;
         default: n = din ? ST_B : ST_C;
      endcase
      return n;
   endfunction

   // Handshake: channel i transfers req_din[i] on a rising clk when req_valid[i] & req_ready[i].
   // req_ready is a combinational one-hot grant, never depends on req_din, and is held low in reset
   // and for any channel being cleared in the same cycle.
   assign eligible = areset_n ? (bus.req_valid & ~bus.ch_clear) : '0;

   always_comb begin
      grant  = '0;
      xfer   = 1'b0;
      gnt_ch = '0;
      cand   = '0;
      for (int k = 0; k < NCH; k++) begin
         cand = CH_W'((int'(ptr_q) + k) % NCH);
         if (!xfer && eligible[cand]) begin
            xfer   = 1'b1;
            gnt_ch = cand;
         end
      end
      if (xfer) grant[gnt_ch] = 1'b1;
   end

   assign gnt_next      = fsm3_next(state_q[gnt_ch], bus.req_din[gnt_ch]);
   assign bus.req_ready = grant;

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         for (int i = 0; i < NCH; i++) begin
            state_q[i] <= ST_A;
            cnt_q[i]   <= '0;
         end
         ptr_q       <= '0;
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         out_dout_q  <= 1'b0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (bus.ch_clear[i]) begin
               state_q[i] <= ST_A;
               cnt_q[i]   <= '0;
            end else if (grant[i]) begin
               state_q[i] <= gnt_next;
               if (gnt_next == ST_D && cnt_q[i] != CNT_MAX) cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
         out_valid_q <= xfer;
         if (xfer) begin
            out_ch_q   <= gnt_ch;
            out_dout_q <= (gnt_next == ST_D);
            ptr_q      <= (int'(gnt_ch) == NCH - 1) ? '0 : gnt_ch + 1'b1;
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_ch    = out_ch_q;
   assign bus.out_dout  = out_dout_q;

   always_comb begin
      bus.dout_vec = '0;
      bus.ctx_dbg  = '0;
      for (int i = 0; i < NCH; i++) begin
         bus.dout_vec[i]       = (state_q[i] == ST_D);
         bus.ctx_dbg[2*i +: 2] = state_q[i];
      end
   end

   // Out-of-range selects never match a loop index, so they read back as zero.
   always_comb begin
      bus.rd_cnt = '0;
      for (int i = 0; i < NCH; i++) begin
         if (bus.rd_ch == CH_W'(i)) bus.rd_cnt = cnt_q[i];
      end
   end
endmodule

// File: tb/tb_fsm3_rr_scheduler.sv
// Self-checking bench for fsm3_rr_scheduler: directed scenarios plus randomized traffic against a
// sequence-detector reference model (new state is D exactly when the last three accepted bits are 1,0,1).
module tb_fsm3_rr_scheduler;
   localparam int NCH     = 4;
   localparam int CH_W    = 2;
   localparam int CNT_W   = 3;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   // ---------------- clock / reset ----------------
   logic clk      = 1'b0;
   logic areset_n = 1'b0;
   always #5 clk = ~clk;

   fsm3_rr_scheduler_if #(.NCH(NCH), .CH_W(CH_W), .CNT_W(CNT_W)) bus ();

   fsm3_rr_scheduler #(.NCH(NCH), .CH_W(CH_W), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .areset_n (areset_n),
      .bus      (bus.slave)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   int         checks   = 0;
   int         failures = 0;
   logic [CH_W:0] exp_q[$];     // {channel, dout} of each accepted step
   logic [CH_W:0] mon_e;
   logic [2:0] m_hist [NCH];    // last accepted bits, newest in bit 0
   int         m_len  [NCH];
   int         m_cnt  [NCH];
   int         m_ptr;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
      end
   endtask

   function automatic logic m_in_d(input int ch);
      return (m_len[ch] >= 3) && (m_hist[ch] == 3'b101);
   endfunction

   function automatic logic [NCH-1:0] m_dout_vec();
      logic [NCH-1:0] v = '0;
      for (int i = 0; i < NCH; i++) v[i] = m_in_d(i);
      return v;
   endfunction

   function automatic int m_grant(input logic [NCH-1:0] v, input logic [NCH-1:0] c);
      for (int k = 0; k < NCH; k++) begin
         int i = (m_ptr + k) % NCH;
         if (v[i] && !c[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_hist[i] = '0;
         m_len[i]  = 0;
         m_cnt[i]  = 0;
      end
      m_ptr = 0;
      exp_q.delete();
   endtask

   task automatic model_edge(input logic [NCH-1:0] v, input logic [NCH-1:0] d, input logic [NCH-1:0] c);
      int g = m_grant(v, c);
      for (int i = 0; i < NCH; i++) begin
         if (c[i]) begin
            m_hist[i] = '0;
            m_len[i]  = 0;
            m_cnt[i]  = 0;
         end
      end
      if (g >= 0) begin
         m_hist[g] = {m_hist[g][1:0], d[g]};
         if (m_len[g] < 3) m_len[g]++;
         if (m_in_d(g) && m_cnt[g] < CNT_MAX) m_cnt[g]++;
         exp_q.push_back({CH_W'(g), m_in_d(g)});
         m_ptr = (g + 1) % NCH;
      end
   endtask

   // ---------------- driver tasks ----------------
   // Entered and left at posedge+1; one call = one clock cycle of stimulus.
   task automatic cycle(input logic [NCH-1:0] v, input logic [NCH-1:0] d, input logic [NCH-1:0] c,
                        input logic [NCH-1:0] want, input bit use_want);
      int g;
      bus.req_valid = v;
      bus.req_din   = d;
      bus.ch_clear  = c;
      g = m_grant(v, c);
      @(negedge clk);
      chk("req_ready", 32'(bus.req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
      if (use_want) chk("req_ready_directed", 32'(bus.req_ready), 32'(want));
      @(posedge clk);
      model_edge(v, d, c);
      #1;
   endtask

   task automatic send_seq(input int ch, input logic [31:0] bits, input int n);
      logic [NCH-1:0] one = '0;
      one[ch] = 1'b1;
      for (int k = n - 1; k >= 0; k--) cycle(one, bits[k] ? one : '0, '0, one, 1'b1);
   endtask

   task automatic apply_reset();
      #1;
      bus.req_valid = '1;
      areset_n      = 1'b0;
      #1;
      model_reset();
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_dout_vec", 32'(bus.dout_vec), 32'd0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_rd_cnt", 32'(bus.rd_cnt), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      bus.req_valid = '0;
      areset_n      = 1'b1;
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (areset_n) begin
         chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            if (bus.out_valid) begin
               chk("out_ch", 32'(bus.out_ch), 32'(mon_e[CH_W:1]));
               chk("out_dout", 32'(bus.out_dout), 32'(mon_e[0]));
            end
         end
         chk("dout_vec", 32'(bus.dout_vec), 32'(m_dout_vec()));
         chk("rd_cnt", 32'(bus.rd_cnt), 32'(m_cnt[bus.rd_ch]));
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      bus.req_valid = '0;
      bus.req_din   = '0;
      bus.ch_clear  = '0;
      bus.rd_ch     = '0;
      model_reset();
      @(posedge clk);
      apply_reset();

      // single channel 1,0,1
      send_seq(0, 32'b101, 3);
      chk("ch0_dout_vec", 32'(bus.dout_vec[0]), 32'd1);
      chk("ch0_rd_cnt", 32'(bus.rd_cnt), 32'd1);

      // overlapping detections on ch1
      bus.rd_ch = 2'd1;
      send_seq(1, 32'b10101, 5);
      #1 chk("ch1_rd_cnt", 32'(bus.rd_cnt), 32'd2);

      // fairness with everyone requesting, then with ch2 idle
      apply_reset();
      cycle(4'b1111, 4'(($urandom)), '0, 4'b0001, 1'b1);
      cycle(4'b1111, 4'(($urandom)), '0, 4'b0010, 1'b1);
      cycle(4'b1111, 4'(($urandom)), '0, 4'b0100, 1'b1);
      cycle(4'b1111, 4'(($urandom)), '0, 4'b1000, 1'b1);
      cycle(4'b1111, 4'(($urandom)), '0, 4'b0001, 1'b1);
      apply_reset();
      cycle(4'b1011, 4'(($urandom)), '0, 4'b0001, 1'b1);
      cycle(4'b1011, 4'(($urandom)), '0, 4'b0010, 1'b1);
      cycle(4'b1011, 4'(($urandom)), '0, 4'b1000, 1'b1);
      cycle(4'b1011, 4'(($urandom)), '0, 4'b0001, 1'b1);
      cycle(4'b1011, 4'(($urandom)), '0, 4'b0010, 1'b1);
      cycle(4'b1011, 4'(($urandom)), '0, 4'b1000, 1'b1);

      // clear collides with a request on a channel sitting in D with count 5
      apply_reset();
      bus.rd_ch = 2'd0;
      send_seq(0, 32'b10101010101, 11);
      chk("ch0_cnt5", 32'(bus.rd_cnt), 32'd5);
      chk("ch0_in_d", 32'(bus.dout_vec[0]), 32'd1);
      cycle(4'b0011, 4'b0011, 4'b0001, 4'b0010, 1'b1);
      chk("clr_cnt", 32'(bus.rd_cnt), 32'd0);
      chk("clr_dout_vec", 32'(bus.dout_vec[0]), 32'd0);

      // counter saturation on ch3
      bus.rd_ch = 2'd3;
      send_seq(3, 32'b10101010101010101, 17);
      #1 chk("ch3_sat", 32'(bus.rd_cnt), CNT_MAX);
      chk("ch3_in_d", 32'(bus.dout_vec[3]), 32'd1);

      // asynchronous reset in the middle of a ch0 stream
      send_seq(0, 32'b10, 2);
      apply_reset();
      send_seq(0, 32'b01, 2);
      chk("post_rst_dout_vec", 32'(bus.dout_vec), 32'd0);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         bus.rd_ch = CH_W'($urandom_range(0, NCH - 1));
         if ($urandom_range(0, 99) == 0) apply_reset();
         else cycle(4'($urandom), 4'($urandom), 4'($urandom & $urandom & $urandom), '0, 1'b0);
      end

      cycle('0, '0, '0, '0, 1'b1);
      cycle('0, '0, '0, '0, 1'b1);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fsm3_rr_scheduler.md
# fsm3_rr_scheduler

Time-multiplexed scheduler that shares one fsm3 next-state evaluator (Moore machine, states A/B/C/D, dout=1 in D) among NCH independent bit streams. It holds a per-channel state context, grants one requester per cycle by round-robin, and steps only the granted channel's context. It reports each step's Moore output on a registered result port and keeps a saturating per-channel detection count. It sits between multiple serial-bit producers and the detection consumers that previously needed one fsm3 instance each.

## Interface
- NCH, 4, number of requester channels (2..16)
- CH_W, $clog2(NCH), channel index width
- CNT_W, 8, width of per-channel hit counter
- clk  in  1  rising-edge clock
- areset_n  in  1  asynchronous active-low reset
- req_valid  in  NCH  channel i has a din bit to submit
- req_din  in  NCH  din bit for channel i
- req_ready  out  NCH  one-hot grant, combinational; transfer on channel i when req_valid[i] & req_ready[i] at rising clk
- ch_clear  in  NCH  synchronous clear of channel i context and counter
- out_valid  out  1  registered: a step completed last cycle
- out_ch  out  CH_W  channel of that step
- out_dout  out  1  Moore output of the channel's new state (1 iff new state D)
- dout_vec  out  NCH  registered per-channel Moore output (state==D)
- rd_ch  in  CH_W  counter read select
- rd_cnt  out  CNT_W  combinational hit count of channel rd_ch

## Operation
- Context per channel: 2-bit state, encoding A=0, B=1, C=2, D=3.
- Transition table (din 0 / din 1): A->A/B, B->C/B, C->A/D, D->C/B.
- Eligible set = req_valid & ~ch_clear; a clearing channel is never granted that cycle.
- Arbiter: round-robin pointer ptr; grant = first eligible channel scanning ptr, ptr+1, ... mod NCH. At most one req_ready bit high; all low if eligible set empty.
- On transfer of channel g: state[g] <= next(state[g], req_din[g]); if next==D, hit_cnt[g] increments, saturating at 2^CNT_W-1; ptr <= (g+1) mod NCH.
- No transfer: ptr holds, no context changes.
- ch_clear[i]: state[i] <= A, hit_cnt[i] <= 0 on that edge; multiple channels may clear at once; clear affects only channel i.
- Non-granted channels: context untouched regardless of req_din.
- dout_vec[i] == (state[i]==D) at all times after each edge.
- rd_cnt = hit_cnt[rd_ch]; rd_ch >= NCH returns 0.

## Timing
- Reset (areset_n low, asynchronous assert): all states A, all counters 0, ptr 0, out_valid 0, out_ch 0, out_dout 0, dout_vec 0. req_ready follows req_valid combinationally even during reset is NOT allowed: req_ready forced 0 while areset_n low.
- Reset deassertion takes effect at next rising clk; first grant possible on first edge after release.
- Grant-to-result latency 1 cycle: transfer at edge k -> out_valid=1, out_ch=g, out_dout=(new state==D) valid between edge k and k+1; out_valid 0 in cycles following no-transfer edges.
- Throughput: one step per cycle total; each channel at least one grant every NCH cycles while continuously valid.
- Reset mid-operation: all contexts lost, any pending out_valid cleared immediately (asynchronous).
- Requesters may drop req_valid at any time; no transfer without req_ready.

## Test plan
- Single channel: reset, ch0 submits 1,0,1 on consecutive cycles (others idle) -> out_dout 0,0,1; out_ch 0 each; dout_vec[0]=1 after third edge; rd_ch=0 gives rd_cnt=1.
- Overlap: ch1 submits 1,0,1,0,1 -> states B,C,D,C,D; out_dout 0,0,1,0,1; rd_cnt(1)=2.
- Fairness: all four req_valid held high from reset -> req_ready sequence 0001,0010,0100,1000,0001; ch2 idle -> grants skip it (0,1,3,0,1,3); each channel's context steps only on its own grants.
- Clear collision: ch0 in D with count 5, ch_clear[0]=1 and req_valid[0]=1 same cycle -> req_ready[0]=0, ch0 state A, count 0, grant passes to next eligible channel.
- Saturation with CNT_W=2: ch3 submits 1,0,1,0,1,0,1,0,1 -> 4 D entries, rd_cnt(3)=3 (saturated), out_dout still 1 on each D entry.
- Async reset mid-stream: assert areset_n low at negedge during ch0 sequence 1,0 -> out_valid, dout_vec, counts 0 immediately; after release ch0 submits 0,1 -> states A,B, out_dout 0,0.
